traffic_phase_ctrl: RTL and testbench

Parametrised N-way intersection phase controller. It is the next generation of the team's fixed 4-way light timer. It serves NUM_DIR approaches round-robin, each with a runtime green time, and adds an amber/all-red clearance sequence, a latched pedestrian walk phase and emergency pre-emption. It drives the per-direction lamp codes and countdown to the display/timer logic downstream.

---
 rtl/traffic_phase_ctrl.sv | 147 ++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: round-robin N-way intersection phase controller with amber/all-red clearance, latched walk and emergency pre-emption
// ports: clk, reset (sync, active-high); tg = per-direction green times; ped_req, em_req/em_dir = latched requests;
//        state, dir, count, color, ped_walk, em_active, cycle_cnt = registered status for the display/timer logic
module traffic_phase_ctrl #(
  parameter int NUM_DIR = 4,
  parameter int CNT_W = 8,
  parameter int T_AMBER = 10,
  parameter int T_CLEAR = 2,
  parameter int T_WALK = 15,
  parameter int T_EMG = 20,
  parameter int DIR_W = $clog2(NUM_DIR)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_DIR*CNT_W-1:0] tg,
  input  logic                     ped_req,
  input  logic                     em_req,
  input  logic [DIR_W-1:0]         em_dir,
  output logic [2:0]               state,
  output logic [DIR_W-1:0]         dir,
  output logic [CNT_W-1:0]         count,
  output logic [2*NUM_DIR-1:0]     color,
  output logic                     ped_walk,
  output logic                     em_active,
  output logic [CNT_W-1:0]         cycle_cnt
);
  localparam logic [2:0] S_ALLRED = 3'd0;
  localparam logic [2:0] S_GREEN = 3'd1;
  localparam logic [2:0] S_AMBER = 3'd2;
  localparam logic [2:0] S_WALK = 3'd3;
  localparam logic [CNT_W-1:0] L_AMBER = CNT_W'(T_AMBER - 1);
  localparam logic [CNT_W-1:0] L_CLEAR = CNT_W'(T_CLEAR - 1);
  localparam logic [CNT_W-1:0] L_WALK = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] L_EMG = CNT_W'(T_EMG - 1);
  localparam logic [DIR_W-1:0] D_LAST = DIR_W'(NUM_DIR - 1);
  logic [2:0]           r_state;
  logic [DIR_W-1:0]     r_dir;
  logic [CNT_W-1:0]     r_count;
  logic                 r_em_active;
  logic [CNT_W-1:0]     r_cycle_cnt;
  logic                 r_ped;
  logic                 r_em;
  logic [DIR_W-1:0]     r_em_dir;
  logic [2*NUM_DIR-1:0] r_color;
  logic                 r_ped_walk;
  logic [2:0]           w_state;
  logic [DIR_W-1:0]     w_dir;
  logic [CNT_W-1:0]     w_count;
  logic                 w_em_active;
  logic [CNT_W-1:0]     w_cycle_cnt;
  logic                 w_ped_clr;
  logic                 w_em_clr;
  logic [2*NUM_DIR-1:0] w_color;
  logic                 w_ped_walk;
  logic [CNT_W-1:0]     w_tg;
  logic [CNT_W-1:0]     w_green_len;
  logic [DIR_W-1:0]     w_dir_inc;
  assign w_tg = tg[r_dir*CNT_W +: CNT_W];
  // a zero green time still gives one cycle of green
  assign w_green_len = (w_tg == '0) ? '0 : w_tg - 1'b1;
  assign w_dir_inc = (r_dir == D_LAST) ? '0 : r_dir + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_ALLRED;
      r_dir <= '0;
      r_count <= L_CLEAR;
      r_em_active <= 1'b0;
      r_cycle_cnt <= '0;
      r_ped <= 1'b0;
      r_em <= 1'b0;
      r_em_dir <= '0;
      r_color <= '0;
      r_ped_walk <= 1'b0;
    end else begin
      r_state <= w_state;
      r_dir <= w_dir;
      r_count <= w_count;
      r_em_active <= w_em_active;
      r_cycle_cnt <= w_cycle_cnt;
      r_ped <= ped_req | (r_ped & ~w_ped_clr);
      r_em <= em_req | (r_em & ~w_em_clr);
      r_color <= w_color;
      r_ped_walk <= w_ped_walk;
      if (em_req) r_em_dir <= em_dir;
    end
  end
  always_comb begin
    w_state = r_state;
    w_dir = r_dir;
    w_count = r_count - 1'b1;
    w_em_active = r_em_active;
    w_cycle_cnt = r_cycle_cnt;
    w_ped_clr = 1'b0;
    w_em_clr = 1'b0;
    case (r_state)
      S_ALLRED: begin
        if (r_count == '0) begin
          w_state = S_GREEN;
          w_count = r_em ? L_EMG : w_green_len;
          w_dir = r_em ? r_em_dir : r_dir;
          w_em_active = r_em;
          w_em_clr = r_em;
        end
      end
      S_GREEN: begin
        // an emergency for the direction already green extends it, even on its last cycle
        if (r_em && r_em_dir == r_dir) begin
          w_count = L_EMG;
          w_em_active = 1'b1;
          w_em_clr = 1'b1;
        end else if (r_count == '0 || (r_em && !r_em_active)) begin
          w_state = S_AMBER;
          w_count = L_AMBER;
        end
      end
      S_AMBER: begin
        if (r_count == '0) begin
          w_dir = w_dir_inc;
          w_cycle_cnt = r_cycle_cnt + CNT_W'(r_dir == D_LAST);
          w_em_active = 1'b0;
          w_state = r_ped ? S_WALK : S_ALLRED;
          w_count = r_ped ? L_WALK : L_CLEAR;
          w_ped_clr = r_ped;
        end
      end
      default: begin
        if (r_count == '0) begin
          w_state = S_ALLRED;
          w_count = L_CLEAR;
        end
      end
    endcase
  end
  always_comb begin
    w_color = '0;
    w_ped_walk = w_state == S_WALK;
    for (int d = 0; d < NUM_DIR; d++)
      if (w_dir == DIR_W'(d)) w_color[2*d +: 2] = w_state == S_GREEN ? 2'b01 : w_state == S_AMBER ? 2'b10 : 2'b00;
  end
  assign state = r_state;
  assign dir = r_dir;
  assign count = r_count;
  assign color = r_color;
  assign ped_walk = r_ped_walk;
  assign em_active = r_em_active;
  assign cycle_cnt = r_cycle_cnt;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: scoreboard bench replaying the phase-sequence scenarios against traffic_phase_ctrl
module tb_traffic_phase_ctrl;
  localparam logic [31:0] TG_DEF = {8'd7, 8'd6, 8'd5, 8'd4};
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] tg = TG_DEF;
  logic        ped_req = 1'b0;
  logic        em_req = 1'b0;
  logic [1:0]  em_dir = 2'd0;
  logic [2:0]  state;
  logic [1:0]  dir;
  logic [7:0]  count;
  logic [7:0]  color;
  logic        ped_walk;
  logic        em_active;
  logic [7:0]  cycle_cnt;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  exp_cc = 8'd0;
  logic [31:0] q[$];
  always #5 clk = ~clk;
  traffic_phase_ctrl #(
    .NUM_DIR(4), .CNT_W(8), .T_AMBER(3), .T_CLEAR(2), .T_WALK(5), .T_EMG(6)
  ) dut (
    .clk(clk), .reset(reset), .tg(tg), .ped_req(ped_req), .em_req(em_req), .em_dir(em_dir),
    .state(state), .dir(dir), .count(count), .color(color), .ped_walk(ped_walk),
    .em_active(em_active), .cycle_cnt(cycle_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask
  function automatic logic [31:0] mk(input int st, input int d, input int c, input int em);
    logic [7:0] col;
    col = 8'h00;
    if (st == 1) col[2*d +: 2] = 2'b01;
    if (st == 2) col[2*d +: 2] = 2'b10;
    return {1'b0, exp_cc, 3'(st), 2'(d), 8'(c), col, st == 3, 1'(em)};
  endfunction
  task automatic push_cnt(input int st, input int d, input int c, input int n, input int em);
    for (int i = 0; i < n; i++) q.push_back(mk(st, d, c - i, em));
  endtask
  task automatic push_seg(input int st, input int d, input int len, input int em);
    push_cnt(st, d, len - 1, len, em);
  endtask
  task automatic cycle(input logic p, input logic e, input logic [1:0] d);
    if (q.size() == 0) chk("queue_empty", 32'd1, 32'd0);
    else chk("phase", {1'b0, cycle_cnt, state, dir, count, color, ped_walk, em_active}, q.pop_front());
    ped_req = p;
    em_req = e;
    em_dir = d;
    @(negedge clk);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0);
  endtask
  task automatic do_reset;
    reset = 1'b1;
    ped_req = 1'b0;
    em_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    exp_cc = 8'd0;
  endtask
  initial begin
    do_reset;
    push_seg(0, 0, 2, 0);
    for (int d = 0; d < 4; d++) begin
      push_seg(1, d, 4 + d, 0);
      push_seg(2, d, 3, 0);
      if (d == 3) exp_cc++;
      push_seg(0, (d + 1) % 4, 2, 0);
    end
    push_seg(1, 0, 4, 0);
    run(48);
    do_reset;
    push_seg(0, 0, 2, 0); push_seg(1, 0, 4, 0); push_seg(2, 0, 3, 0);
    push_seg(0, 1, 2, 0); push_seg(1, 1, 5, 0); push_seg(2, 1, 3, 0);
    push_seg(3, 2, 5, 0); push_seg(0, 2, 2, 0); push_seg(1, 2, 6, 0);
    run(11);
    cycle(1'b1, 1'b0, 2'd0);
    run(20);
    do_reset;
    push_seg(0, 0, 2, 0); push_cnt(1, 0, 3, 3, 0); push_seg(2, 0, 3, 0);
    push_seg(0, 1, 2, 0); push_seg(1, 3, 6, 1); push_seg(2, 3, 3, 1);
    exp_cc++;
    push_seg(0, 0, 2, 0); push_seg(1, 0, 4, 0);
    run(3);
    cycle(1'b0, 1'b1, 2'd3);
    run(21);
    do_reset;
    push_seg(0, 0, 2, 0); push_seg(1, 0, 4, 0); push_seg(2, 0, 3, 0);
    push_seg(0, 1, 2, 0); push_seg(1, 1, 5, 0); push_seg(2, 1, 3, 0);
    push_seg(0, 2, 2, 0); push_seg(1, 2, 6, 0); push_seg(1, 2, 6, 1);
    push_seg(2, 2, 3, 1); push_seg(0, 3, 2, 0); push_seg(1, 3, 7, 0);
    run(25);
    cycle(1'b0, 1'b1, 2'd2);
    run(19);
    tg = {8'd7, 8'd6, 8'd0, 8'd4};
    do_reset;
    push_seg(0, 0, 2, 0); push_seg(1, 0, 4, 0); push_seg(2, 0, 3, 0);
    push_seg(0, 1, 2, 0); push_seg(1, 1, 1, 0); push_seg(2, 1, 3, 0);
    push_seg(0, 2, 2, 0); push_seg(1, 2, 6, 0);
    run(23);
    tg = TG_DEF;
    do_reset;
    push_seg(0, 0, 2, 0); push_seg(1, 0, 4, 0); push_seg(2, 0, 3, 0);
    push_seg(0, 1, 2, 0); push_seg(1, 1, 5, 0); push_seg(2, 1, 3, 0);
    push_cnt(3, 2, 4, 2, 0);
    run(11);
    cycle(1'b1, 1'b0, 2'd0);
    run(7);
    cycle(1'b0, 1'b0, 2'd0);
    cycle(1'b1, 1'b0, 2'd0);
    do_reset;
    push_seg(0, 0, 2, 0); push_seg(1, 0, 4, 0); push_seg(2, 0, 3, 0);
    push_seg(0, 1, 2, 0); push_seg(1, 1, 5, 0);
    run(16);
    do_reset;
    push_seg(0, 0, 2, 0); push_cnt(1, 0, 3, 3, 0); push_seg(2, 0, 3, 0);
    push_seg(3, 1, 5, 0); push_seg(0, 1, 2, 0); push_seg(1, 2, 6, 1);
    push_seg(2, 2, 3, 1); push_seg(0, 3, 2, 0); push_seg(1, 3, 7, 0);
    run(3);
    cycle(1'b1, 1'b1, 2'd2);
    run(29);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
